local_store_arbiter: RTL and testbench

//  Shares the single-port 2048x128b local store between three requesters: DMA (MFC), load/store pipe, instruction fetch.

---
 rtl/local_store_pkg.sv | 19 +
 rtl/ls_owner_pipe.sv | 32 +++
 rtl/local_store_arbiter.sv | 162 ++++++++++++++++
 tb/tb_local_store_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_store_pkg.sv
// Shared constants and owner tag for the local store arbiter slice.
package local_store_pkg;

  localparam int LS_ADDR_W = 11;
  localparam int LS_DATA_W = 128;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DMA  = 2'd1,
    OWN_LS   = 2'd2,
    OWN_IF   = 2'd3
  } ls_owner_t;

  // A branch flush turns any fetch tag into an empty slot.
  function automatic ls_owner_t scrub_if(input ls_owner_t tag, input logic flush);
    return (flush && (tag == OWN_IF)) ? OWN_NONE : tag;
  endfunction

endpackage

// File: rtl/ls_owner_pipe.sv
// Delay line carrying the owner of each read from command issue to data return.
module ls_owner_pipe
  import local_store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      clr_i,
  input  logic      flush_if_i,
  input  ls_owner_t tag_i,
  output ls_owner_t tag_o
);

  ls_owner_t stage_q [DEPTH];

  // Shift owner tags; clear empties the pipe, flush removes every fetch tag.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= OWN_NONE;
      end
    end else begin
      stage_q[0] <= scrub_if(tag_i, flush_if_i);
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= scrub_if(stage_q[i-1], flush_if_i);
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/local_store_arbiter.sv
// Fixed-priority DMA > LS > IF arbiter for the single-port local store, with a
// DMA burst limit, fetch anti-starvation and per-requester read return.
module local_store_arbiter
  import local_store_pkg::*;
#(
  parameter int ADDR_W    = LS_ADDR_W,
  parameter int DATA_W    = LS_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int DMA_BURST = 8,
  parameter int IF_STARVE = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              if_flush_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int RUN_W  = $clog2(DMA_BURST + 1);
  localparam int WAIT_W = $clog2(IF_STARVE + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(DMA_BURST);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(IF_STARVE);

  logic [RUN_W-1:0]  dma_run_q, dma_run_d;
  logic [WAIT_W-1:0] if_wait_q, if_wait_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  ls_owner_t winner;
  ls_owner_t rd_tag;
  ls_owner_t ret_tag;
  logic      if_ok;
  logic      dma_masked;

  // Pick this cycle's winner; a flushed fetch is never eligible.
  always_comb begin
    if_ok      = if_req_i & ~if_flush_i;
    dma_masked = (dma_run_q == RUN_MAX) & (ls_req_i | if_ok);
    winner     = OWN_NONE;
    if (reset_i) begin
      winner = OWN_NONE;
    end else if (if_ok && (if_wait_q == WAIT_MAX)) begin
      winner = OWN_IF;
    end else if (dma_req_i && !dma_masked) begin
      winner = OWN_DMA;
    end else if (ls_req_i) begin
      winner = OWN_LS;
    end else if (if_ok) begin
      winner = OWN_IF;
    end else begin
      winner = OWN_NONE;
    end
  end

  assign dma_gnt_o = (winner == OWN_DMA);
  assign ls_gnt_o  = (winner == OWN_LS);
  assign if_gnt_o  = (winner == OWN_IF);

  // Burst and starvation counters, both saturating.
  always_comb begin
    if (winner == OWN_DMA) begin
      dma_run_d = (dma_run_q == RUN_MAX) ? RUN_MAX : dma_run_q + RUN_W'(1);
    end else begin
      dma_run_d = '0;
    end
    if (!if_req_i || if_flush_i || (winner == OWN_IF)) begin
      if_wait_d = '0;
    end else begin
      if_wait_d = (if_wait_q == WAIT_MAX) ? WAIT_MAX : if_wait_q + WAIT_W'(1);
    end
  end

  // Next memory command; address and data hold their last value when idle.
  always_comb begin
    mem_en_d    = (winner != OWN_NONE);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (winner)
      OWN_DMA: begin
        mem_we_d    = dma_we_i;
        mem_addr_d  = dma_addr_i;
        mem_wdata_d = dma_wdata_i;
      end
      OWN_LS: begin
        mem_we_d    = ls_we_i;
        mem_addr_d  = ls_addr_i;
        mem_wdata_d = ls_wdata_i;
      end
      OWN_IF: begin
        mem_addr_d  = if_addr_i;
      end
      default: begin
        mem_we_d    = 1'b0;
      end
    endcase
    rd_tag = (mem_en_d && !mem_we_d) ? winner : OWN_NONE;
  end

  // Command register and arbitration state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      dma_run_q   <= '0;
      if_wait_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      dma_run_q   <= dma_run_d;
      if_wait_q   <= if_wait_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  ls_owner_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_owner_pipe (
    .clk_i      (clock_i),
    .clr_i      (reset_i),
    .flush_if_i (if_flush_i),
    .tag_i      (rd_tag),
    .tag_o      (ret_tag)
  );

  // A command still held in the register when reset arrives is never issued.
  assign mem_en_o    = mem_en_q & ~reset_i;
  assign mem_we_o    = mem_we_q & ~reset_i;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign dma_rvalid_o = (ret_tag == OWN_DMA) & ~reset_i;
  assign ls_rvalid_o  = (ret_tag == OWN_LS) & ~reset_i;
  assign if_rvalid_o  = (ret_tag == OWN_IF) & ~reset_i & ~if_flush_i;
  assign rdata_o      = mem_rdata_i;

endmodule

// File: tb/tb_local_store_arbiter.sv
// Directed and random bench for local_store_arbiter against a queue-based reference model.
module tb_local_store_arbiter;

  localparam int AW = 11;
  localparam int DW = 128;
  localparam int RD_LAT = 1;
  localparam int DMA_BURST = 8;
  localparam int IF_STARVE = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_req = 1'b0, d_we = 1'b0, l_req = 1'b0, l_we = 1'b0, i_req = 1'b0, flush = 1'b0;
  logic [AW-1:0] d_addr = '0, l_addr = '0, i_addr = '0;
  logic [DW-1:0] d_wd = '0, l_wd = '0;
  logic dma_gnt, dma_rvalid, ls_gnt, ls_rvalid, if_gnt, if_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  local_store_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .DMA_BURST(DMA_BURST), .IF_STARVE(IF_STARVE)
  ) dut (
    .clock_i(clk), .reset_i(rst),
    .dma_req_i(d_req), .dma_we_i(d_we), .dma_addr_i(d_addr), .dma_wdata_i(d_wd),
    .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid),
    .ls_req_i(l_req), .ls_we_i(l_we), .ls_addr_i(l_addr), .ls_wdata_i(l_wd),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid),
    .if_req_i(i_req), .if_addr_i(i_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
    .if_flush_i(flush), .rdata_o(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    logic [31:0] w;
    w = i;
    return {w, 32'hC0DE_0000 ^ w, ~w, 32'h1234_5678 + w};
  endfunction

  // Behavioural SRAM seen by the DUT.
  logic [DW-1:0] sram [2048];
  bit            sram_wr [2048];
  logic [DW-1:0] rd_sh [RD_LAT];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        sram[mem_addr]    <= mem_wdata;
        sram_wr[mem_addr] <= 1'b1;
      end else begin
        rd_sh[0] <= sram_wr[mem_addr] ? sram[mem_addr] : init_word(int'(mem_addr));
      end
    end
    for (int k = 1; k < RD_LAT; k++) rd_sh[k] <= rd_sh[k-1];
  end
  assign mem_rdata = rd_sh[RD_LAT-1];

  // Reference model state.
  typedef struct { int due; int own; logic [DW-1:0] data; } rd_t;
  rd_t q[$];
  logic [DW-1:0] ref_mem [2048];
  int m_run = 0, m_wait = 0;
  bit p_en = 0, p_we = 0;
  int p_own = 0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wd = '0;

  logic [2:0] obs_g, obs_rv;
  logic obs_en;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wd, obs_rdata;

  function automatic logic [2:0] own_bits(input int own);
    return (own == 1) ? 3'b100 : (own == 2) ? 3'b010 : (own == 3) ? 3'b001 : 3'b000;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: compare DUT against the model at the falling edge, then advance the model.
  task automatic step();
    int own;
    bit ife;
    logic [2:0] erv;
    logic [DW-1:0] ed;
    rd_t nq[$];
    rd_t e;
    @(negedge clk);
    ife = i_req && !flush;
    own = 0;
    if (!rst) begin
      if (ife && m_wait == IF_STARVE) own = 3;
      else if (d_req && !(m_run == DMA_BURST && (l_req || ife))) own = 1;
      else if (l_req) own = 2;
      else if (ife) own = 3;
    end
    if (flush) begin
      foreach (q[k]) if (q[k].own != 3) nq.push_back(q[k]);
      q = nq;
      if (p_own == 3) p_own = 0;
    end
    erv = 3'b000;
    ed = '0;
    if (!rst) foreach (q[k]) if (q[k].due == cyc) begin erv = own_bits(q[k].own); ed = q[k].data; end
    obs_g = {dma_gnt, ls_gnt, if_gnt};
    obs_rv = {dma_rvalid, ls_rvalid, if_rvalid};
    obs_en = mem_en; obs_addr = mem_addr; obs_wd = mem_wdata; obs_rdata = rdata;
    check("gnt", DW'(obs_g), DW'(own_bits(own)));
    check("mem_en", DW'(mem_en), DW'(p_en && !rst));
    check("mem_we", DW'(mem_we), DW'(p_we && !rst));
    if (p_en && !rst) check("mem_addr", DW'(mem_addr), DW'(p_addr));
    if (p_en && p_we && !rst) check("mem_wdata", mem_wdata, p_wd);
    check("rvalid", DW'(obs_rv), DW'(erv));
    if (erv != 3'b000) check("rdata", rdata, ed);
    if (rst) begin
      q.delete();
      m_run = 0; m_wait = 0; p_en = 0; p_we = 0; p_own = 0; p_addr = '0; p_wd = '0;
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      if (p_en) begin
        if (p_we) ref_mem[p_addr] = p_wd;
        else if (p_own != 0) begin
          e.due = cyc + RD_LAT; e.own = p_own; e.data = ref_mem[p_addr];
          q.push_back(e);
        end
      end
      p_en = (own != 0);
      p_own = own;
      p_we = (own == 1) ? d_we : (own == 2) ? l_we : 1'b0;
      if (own == 1) begin p_addr = d_addr; p_wd = d_wd; end
      else if (own == 2) begin p_addr = l_addr; p_wd = l_wd; end
      else if (own == 3) p_addr = i_addr;
      m_run = (own == 1) ? ((m_run == DMA_BURST) ? DMA_BURST : m_run + 1) : 0;
      m_wait = (!i_req || flush || own == 3) ? 0 : ((m_wait == IF_STARVE) ? IF_STARVE : m_wait + 1);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    d_req = 1'b0; l_req = 1'b0; i_req = 1'b0; flush = 1'b0; rst = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int k = 0; k < 2048; k++) ref_mem[k] = init_word(k);
    @(posedge clk);
    #1;
    // Reset: no grant even with requests pending, command register empty.
    step();
    d_req = 1'b1; l_req = 1'b1; i_req = 1'b1;
    step();
    check("rst_gnt", DW'(obs_g), DW'(3'b000));
    idle(1);
    check("rst_addr", DW'(obs_addr), DW'(0));
    check("rst_wdata", obs_wd, '0);

    // All three request, DMA reads address 5.
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'd5; l_req = 1'b1; l_we = 1'b0; l_addr = 11'd6;
    i_req = 1'b1; i_addr = 11'd7;
    step();
    check("s1_gnt0", DW'(obs_g), DW'(3'b100));
    d_req = 1'b0;
    step();
    check("s1_en1", DW'(obs_en), DW'(1));
    check("s1_addr1", DW'(obs_addr), DW'(5));
    l_req = 1'b0; i_req = 1'b0;
    step();
    check("s1_rv2", DW'(obs_rv), DW'(3'b100));
    check("s1_rdata2", obs_rdata, init_word(5));
    idle(4);

    // DMA and LS continuous: 8 DMA, 1 LS, 8 DMA; then DMA alone every cycle.
    d_req = 1'b1; d_we = 1'b0; l_req = 1'b1; l_we = 1'b0;
    for (int k = 0; k < 17; k++) begin
      d_addr = AW'(k);
      step();
      check("burst", DW'(obs_g), DW'((k == 8) ? 3'b010 : 3'b100));
    end
    l_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("dma_alone", DW'(obs_g), DW'(3'b100));
    end
    idle(4);

    // LS and IF continuous: IF wins after 16 cycles of waiting.
    l_req = 1'b1; l_we = 1'b0; i_req = 1'b1; i_addr = 11'd20;
    for (int k = 0; k < 18; k++) begin
      step();
      check("starve", DW'(obs_g), DW'((k == 16) ? 3'b001 : 3'b010));
    end
    idle(4);

    // LS write then IF read of same address returns new data.
    l_req = 1'b1; l_we = 1'b1; l_addr = 11'd3; l_wd = {4{32'hA5A5_1234}};
    step();
    check("raw_wr", DW'(obs_g), DW'(3'b010));
    l_req = 1'b0; i_req = 1'b1; i_addr = 11'd3;
    step();
    check("raw_rd", DW'(obs_g), DW'(3'b001));
    i_req = 1'b0;
    step();
    step();
    check("raw_rv", DW'(obs_rv), DW'(3'b001));
    check("raw_data", obs_rdata, {4{32'hA5A5_1234}});
    idle(3);

    // Flush kills the earlier fetch; LS read in the flush cycle still returns.
    i_req = 1'b1; i_addr = 11'd7;
    step();
    check("fl_gnt0", DW'(obs_g), DW'(3'b001));
    flush = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 11'd9;
    step();
    check("fl_gnt1", DW'(obs_g), DW'(3'b010));
    flush = 1'b0; l_req = 1'b0; i_req = 1'b0;
    step();
    check("fl_rv2", DW'(obs_rv), DW'(3'b000));
    step();
    check("fl_rv3", DW'(obs_rv), DW'(3'b010));
    idle(3);

    // Reset right after a DMA read grant.
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'd5;
    step();
    check("mr_gnt", DW'(obs_g), DW'(3'b100));
    d_req = 1'b0; rst = 1'b1;
    step();
    check("mr_en", DW'(obs_en), DW'(0));
    rst = 1'b0;
    step();
    check("mr_rv2", DW'(obs_rv), DW'(3'b000));
    step();
    check("mr_rv3", DW'(obs_rv), DW'(3'b000));
    d_req = 1'b1; l_req = 1'b1; l_we = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      check("mr_burst", DW'(obs_g), DW'((k == 8) ? 3'b010 : 3'b100));
    end
    idle(4);

    // Random traffic: requests held until granted.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 11) == 0);
      if (!d_req && $urandom_range(0, 3) != 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1) == 0; d_addr = AW'($urandom_range(0, 15));
        d_wd = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!l_req && $urandom_range(0, 1) != 0) begin
        l_req = 1'b1; l_we = $urandom_range(0, 1) == 0; l_addr = AW'($urandom_range(0, 15));
        l_wd = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!i_req && $urandom_range(0, 1) != 0) begin
        i_req = 1'b1; i_addr = AW'($urandom_range(0, 15));
      end
      step();
      if (obs_g[2] || rst) d_req = 1'b0;
      if (obs_g[1] || rst) l_req = 1'b0;
      if (obs_g[0] || rst || flush) i_req = 1'b0;
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
